// File: rtl/io_input_debounce_if.sv
// CPU data-bus port of the switch input block: the CPU side is master and the peripheral is slave.
// One access per cycle: ce qualifies the cycle, and we selects write (1) or read (0). There are no wait states.
interface io_input_debounce_if;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [31:0] dataIn;
   logic [31:0] dataOut;

   modport master (output ce, output we, output addr, output dataIn, input dataOut);
   modport slave  (input ce, input we, input addr, input dataIn, output dataOut);
endinterface

// File: rtl/io_input_debounce.sv
// Switch input peripheral: 2-flop sync plus per-bit debounce, sticky rising-edge events, and a masked irq.
// Registers: STATE (RO level), EVENT (read-to-clear / write-1-to-clear), MASK (RW irq enable).
module io_input_debounce #(
   parameter int          N_IN       = 16,
   parameter int          DEB_CYCLES = 20000,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
   input  logic                clk,
   input  logic                rst,
   io_input_debounce_if.slave  bus,
   input  logic [N_IN-1:0]     sw,
   output logic                irq
);

   localparam int          CW         = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
   localparam logic [31:0] ADDR_STATE = BASE_ADDR;
   localparam logic [31:0] ADDR_EVENT = BASE_ADDR + 32'd4;
   localparam logic [31:0] ADDR_MASK  = BASE_ADDR + 32'd8;

   logic [N_IN-1:0] r_sync1;
   logic [N_IN-1:0] r_sync2;
   logic [N_IN-1:0] r_stable;
   logic [N_IN-1:0] r_event;
   logic [N_IN-1:0] r_mask;

   logic [N_IN-1:0] w_stable_next;
   logic [N_IN-1:0] w_rise;
   logic [N_IN-1:0] w_ev_clr;
   logic [N_IN-1:0] w_event_next;
   logic [N_IN-1:0] w_mask_next;
   logic [31:0]     w_rd_data;
   logic            w_rd_access;
   logic            w_wr_access;
   logic            w_sel_state;
   logic            w_sel_event;
   logic            w_sel_mask;
   logic            w_unused_din;

   assign w_rd_access  = bus.ce & ~bus.we;
   assign w_wr_access  = bus.ce & bus.we;
   assign w_sel_state  = (bus.addr == ADDR_STATE);
   assign w_sel_event  = (bus.addr == ADDR_EVENT);
   assign w_sel_mask   = (bus.addr == ADDR_MASK);
   assign w_unused_din = ^bus.dataIn;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sw;
         r_sync2 <= r_sync1;
      end
   end

   // Any disagreement shorter than DEB_CYCLES restarts the count, which is how glitches are rejected.
   for (genvar g = 0; g < N_IN; g++) begin : g_deb
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                          r_cnt <= '0;
         else if (r_sync2[g] == r_stable[g]) r_cnt <= '0;
         else if (r_cnt == CNT_MAX)          r_cnt <= '0;
         else                                r_cnt <= r_cnt + 1'b1;
      end

      assign w_stable_next[g] = ((r_sync2[g] != r_stable[g]) && (r_cnt == CNT_MAX))
                                ? r_sync2[g] : r_stable[g];
   end

   assign w_rise = w_stable_next & ~r_stable;

   always_comb begin
      w_ev_clr = '0;
      if (w_rd_access && w_sel_event)      w_ev_clr = '1;
      else if (w_wr_access && w_sel_event) w_ev_clr = bus.dataIn[N_IN-1:0];
   end

   // Rise is OR-ed in after the clear so a coincident edge survives a clearing access.
   assign w_event_next = (r_event & ~w_ev_clr) | w_rise;
   assign w_mask_next  = (w_wr_access && w_sel_mask) ? bus.dataIn[N_IN-1:0] : r_mask;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stable <= '0;
         r_event  <= '0;
         r_mask   <= '0;
         irq      <= 1'b0;
      end else begin
         r_stable <= w_stable_next;
         r_event  <= w_event_next;
         r_mask   <= w_mask_next;
         irq      <= |(w_event_next & w_mask_next);
      end
   end

   always_comb begin
      w_rd_data = '0;
      if (rst && w_rd_access) begin
         if (w_sel_state)      w_rd_data[N_IN-1:0] = r_stable;
         else if (w_sel_event) w_rd_data[N_IN-1:0] = r_event;
         else if (w_sel_mask)  w_rd_data[N_IN-1:0] = r_mask;
      end
   end

   assign bus.dataOut = w_rd_data;

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with DEB_CYCLES=4 and BASE_ADDR=0x100.
// A per-cycle vector table covers the step and glitch cases; hand-written sequences cover the multi-cycle corners.
module tb_io_input_debounce;
   localparam logic [31:0] A_STATE = 32'h100;
   localparam logic [31:0] A_EVENT = 32'h104;
   localparam logic [31:0] A_MASK  = 32'h108;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] sw  = '0;
   logic        irq;

   io_input_debounce_if bus ();

   io_input_debounce #(.N_IN(16), .DEB_CYCLES(4), .BASE_ADDR(32'h100)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .sw  (sw),
      .irq (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [31:0] din;
      logic [15:0] sw;
      logic [31:0] exp_dout;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic bus_idle();
      bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.dataIn = '0;
   endtask

   // Combinational look at a register without a clock edge, so nothing is cleared.
   task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
      #1 chk(name, bus.dataOut, exp);
      bus.ce = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
      #1 chk(name, bus.dataOut, exp);
      @(posedge clk);
      @(negedge clk);
      bus_idle();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.dataIn = d;
      #1 chk("wr_dout_zero", bus.dataOut, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus_idle();
   endtask

   task automatic add(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [15:0] s, input logic [31:0] ed, input logic ei);
      vecs.push_back('{ce: ce, we: we, addr: a, din: d, sw: s, exp_dout: ed, exp_irq: ei});
   endtask

   initial begin
      bus_idle();
      // Table: step on sw[3] visible after exactly 6 edges, then EVENT read-to-clear.
      for (int i = 0; i < 6; i++) add(1, 0, A_STATE, 0, 16'h0008, 32'h0, 0);
      add(1, 0, A_STATE, 0, 16'h0008, 32'h8, 0);
      add(1, 0, A_EVENT, 0, 16'h0008, 32'h8, 0);
      add(1, 0, A_EVENT, 0, 16'h0008, 32'h0, 0);
      add(0, 0, A_EVENT, 0, 16'h0008, 32'h0, 0);
      // Table: 3-cycle glitch on sw[0] is rejected.
      for (int i = 0; i < 3; i++) add(1, 0, A_STATE, 0, 16'h0009, 32'h8, 0);
      for (int i = 0; i < 5; i++) add(1, 0, A_STATE, 0, 16'h0008, 32'h8, 0);
      add(1, 0, A_EVENT, 0, 16'h0008, 32'h0, 0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_irq", 32'(irq), 32'h0);
      peek("rst_dout_in_reset", A_STATE, 32'h0);
      rst = 1'b1;
      peek("rst_state", A_STATE, 32'h0);
      peek("rst_mask", A_MASK, 32'h0);
      rd("rst_event", A_EVENT, 32'h0);
      bus.addr = A_EVENT;
      #1 chk("ce0_dout", bus.dataOut, 32'h0);
      bus_idle();
      chk("rst_irq_after", 32'(irq), 32'h0);

      foreach (vecs[i]) begin
         bus.ce = vecs[i].ce; bus.we = vecs[i].we; bus.addr = vecs[i].addr;
         bus.dataIn = vecs[i].din; sw = vecs[i].sw;
         #1;
         chk($sformatf("vec%0d_dout", i), bus.dataOut, vecs[i].exp_dout);
         chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
         @(posedge clk);
         @(negedge clk);
      end
      bus_idle();

      // 10-cycle pulse on sw[0]: level rises, falls, and leaves an event.
      sw = 16'h0009;
      tick_n(5); peek("pulse_state_e5", A_STATE, 32'h8);
      tick_n(1); peek("pulse_state_e6", A_STATE, 32'h9);
      tick_n(4); sw = 16'h0008;
      tick_n(5); peek("pulse_fall_e5", A_STATE, 32'h9);
      tick_n(1); peek("pulse_fall_e6", A_STATE, 32'h8);
      rd("pulse_event", A_EVENT, 32'h1);

      // Masked interrupt on bit4, W1C clear, unmasked bit5 stays quiet.
      wr(A_MASK, 32'h0000_0010);
      peek("mask_rb", A_MASK, 32'h10);
      sw = 16'h0018;
      tick_n(5); chk("irq_before", 32'(irq), 32'h0);
      tick_n(1); chk("irq_bit4", 32'(irq), 32'h1);
      peek("event_bit4", A_EVENT, 32'h10);
      wr(A_EVENT, 32'h0000_0010);
      chk("irq_w1c", 32'(irq), 32'h0);
      peek("event_w1c", A_EVENT, 32'h0);
      sw = 16'h0038;
      tick_n(6); peek("event_bit5", A_EVENT, 32'h20);
      chk("irq_unmasked", 32'(irq), 32'h0);
      tick_n(1); chk("irq_unmasked2", 32'(irq), 32'h0);
      wr(A_STATE, 32'h0000_FFFF);
      peek("state_ro", A_STATE, 32'h38);
      peek("unmapped_10c", 32'h10C, 32'h0);
      peek("unmapped_0", 32'h0, 32'h0);
      rd("event_bit5_rd", A_EVENT, 32'h20);

      // Read-clear coinciding with the rising edge of bit2.
      sw = 16'h003C;
      tick_n(5);
      rd("coincide_rd", A_EVENT, 32'h0);
      peek("coincide_kept", A_EVENT, 32'h4);
      rd("coincide_rd2", A_EVENT, 32'h4);
      peek("coincide_clr", A_EVENT, 32'h0);

      // Asynchronous reset mid-debounce with MASK and EVENT set.
      wr(A_MASK, 32'h0000_FFFF);
      sw = 16'h007C;
      tick_n(6);
      peek("pre_rst_event", A_EVENT, 32'h40);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      sw = 16'h007E;
      tick_n(3);
      #2 rst = 1'b0;
      #1 chk("async_rst_irq", 32'(irq), 32'h0);
      peek("async_rst_dout", A_MASK, 32'h0);
      sw = 16'h0002;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      peek("post_rst_state", A_STATE, 32'h0);
      peek("post_rst_mask", A_MASK, 32'h0);
      peek("post_rst_event", A_EVENT, 32'h0);
      chk("post_rst_irq", 32'(irq), 32'h0);
      tick_n(5); peek("held_event_e5", A_EVENT, 32'h0);
      tick_n(1); peek("held_event_e6", A_EVENT, 32'h2);
      peek("held_state_e6", A_STATE, 32'h2);
      chk("held_irq", 32'(irq), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
